// File: rtl/mul_writeback.sv
// rtl/mul_writeback.sv - writeback stage for the 64x64 signed multiplier
//
// Accepts one 2*XLEN product per valid/ready handshake and drains it to the
// register-file write port as up to two beats, LO then HI. It also keeps
// architectural HI/LO copies, a sticky overflow flag and a retired counter.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready product handshake from the multiplier
//   in_product        {HI, LO} product
//   in_overflow       multiplier overflow for this product
//   in_rd_lo/in_rd_hi destinations of LO/HI halves (0 = skip that half)
//   wb_valid/wb_ready writeback beat handshake
//   wb_rd/wb_data     beat destination and data
//   wb_last           final beat of the transaction
//   hi_q/lo_q         HI/LO of the last accepted product
//   ovf_sticky        sticky overflow flag, ovf_clear clears it
//   retired           accepted-product counter (wraps)
//   busy              a transaction is being drained
module mul_writeback #(
  parameter int XLEN  = 64,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*XLEN-1:0] in_product,
  input  logic              in_overflow,
  input  logic [RD_W-1:0]   in_rd_lo,
  input  logic [RD_W-1:0]   in_rd_hi,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_last,
  output logic [XLEN-1:0]   hi_q,
  output logic [XLEN-1:0]   lo_q,
  output logic              ovf_sticky,
  input  logic              ovf_clear,
  output logic [CNT_W-1:0]  retired,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t          state;
  logic [RD_W-1:0] rd_hi_q;
  logic            accept;

  assign wb_valid = (state != IDLE);
  assign busy     = (state != IDLE);
  // A new product may enter on the same edge that retires the final beat,
  // which gives back-to-back transactions without a bubble.
  assign in_ready = ~rst & ((state == IDLE) | (wb_valid & wb_ready & wb_last));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_hi_q    <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_last    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      ovf_sticky <= 1'b0;
      retired    <= '0;
    end else begin
      // Set has priority over clear so an overflow is never lost.
      if (accept && in_overflow) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clear) begin
        ovf_sticky <= 1'b0;
      end

      if (accept) begin
        // hi_q doubles as the pending HI payload: no further product can be
        // accepted until this transaction's last beat retires.
        hi_q    <= in_product[2*XLEN-1:XLEN];
        lo_q    <= in_product[XLEN-1:0];
        rd_hi_q <= in_rd_hi;
        retired <= retired + CNT_W'(1);
        if (in_rd_lo != '0) begin
          state   <= SEND_LO;
          wb_rd   <= in_rd_lo;
          wb_data <= in_product[XLEN-1:0];
          wb_last <= (in_rd_hi == '0);
        end else if (in_rd_hi != '0) begin
          state   <= SEND_HI;
          wb_rd   <= in_rd_hi;
          wb_data <= in_product[2*XLEN-1:XLEN];
          wb_last <= 1'b1;
        end else begin
          state   <= IDLE;
          wb_rd   <= '0;
          wb_data <= '0;
          wb_last <= 1'b0;
        end
      end else if (wb_valid && wb_ready) begin
        if (state == SEND_LO && rd_hi_q != '0) begin
          state   <= SEND_HI;
          wb_rd   <= rd_hi_q;
          wb_data <= hi_q;
          wb_last <= 1'b1;
        end else begin
          state   <= IDLE;
          wb_rd   <= '0;
          wb_data <= '0;
          wb_last <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_writeback.sv
// tb/tb_mul_writeback.sv - directed self-checking bench for mul_writeback
module tb_mul_writeback;

  localparam int XLEN  = 64;
  localparam int RD_W  = 5;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2*XLEN-1:0] in_product;
  logic              in_overflow;
  logic [RD_W-1:0]   in_rd_lo;
  logic [RD_W-1:0]   in_rd_hi;
  logic              wb_valid;
  logic              wb_ready;
  logic [RD_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              wb_last;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              ovf_sticky;
  logic              ovf_clear;
  logic [CNT_W-1:0]  retired;
  logic              busy;

  int errors = 0;
  int checks = 0;

  mul_writeback #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_overflow(in_overflow), .in_rd_lo(in_rd_lo), .in_rd_hi(in_rd_hi),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_last(wb_last),
    .hi_q(hi_q), .lo_q(lo_q), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear),
    .retired(retired), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] p;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_product = '0; in_overflow = 1'b0;
    in_rd_lo = '0; in_rd_hi = '0; wb_ready = 1'b0; ovf_clear = 1'b0;
    tick(); tick();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_retired", retired, 0);
    check("rst_hi_lo", {hi_q, lo_q}, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_wb_fields", {wb_rd, wb_data, wb_last}, 0);

    // Basic two-beat transaction
    p = 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE;
    in_valid = 1'b1; in_product = p; in_rd_lo = 5'd3; in_rd_hi = 5'd4; wb_ready = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    check("b1_valid", wb_valid, 1);
    check("b1_rd", wb_rd, 3);
    check("b1_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
    check("b1_last", wb_last, 0);
    check("b1_in_ready", in_ready, 0);
    check("b1_retired", retired, 1);
    check("b1_lo_q", lo_q, 64'hFFFF_FFFF_FFFF_FFFE);
    check("b1_hi_q", hi_q, 64'h1);
    tick();
    check("b2_valid", wb_valid, 1);
    check("b2_rd", wb_rd, 4);
    check("b2_data", wb_data, 64'h1);
    check("b2_last", wb_last, 1);
    check("b2_in_ready", in_ready, 1);
    tick();
    check("b_done_valid", wb_valid, 0);

    // Backpressure on the LO beat; later input changes must be ignored
    p = {64'h2222_3333_4444_5555, 64'h1111_AAAA_BBBB_CCCC};
    wb_ready = 1'b0;
    in_valid = 1'b1; in_product = p; in_rd_lo = 5'd5; in_rd_hi = 5'd6;
    tick();
    in_valid = 1'b0; in_product = '1; in_rd_lo = 5'd31; in_rd_hi = 5'd30;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stable", {wb_valid, wb_rd, wb_data, wb_last}, {1'b1, 5'd5, 64'h1111_AAAA_BBBB_CCCC, 1'b0});
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    check("bp_hi", {wb_valid, wb_rd, wb_data, wb_last}, {1'b1, 5'd6, 64'h2222_3333_4444_5555, 1'b1});
    check("bp_retired", retired, 2);
    tick();
    check("bp_done", wb_valid, 0);

    // Single LO beat (rd_hi = 0)
    in_valid = 1'b1; in_product = {64'h7, 64'h77}; in_rd_lo = 5'd7; in_rd_hi = 5'd0;
    tick();
    in_valid = 1'b0; #1;
    check("single", {wb_valid, wb_rd, wb_data, wb_last}, {1'b1, 5'd7, 64'h77, 1'b1});
    check("single_in_ready", in_ready, 1);
    tick();
    check("single_done", wb_valid, 0);

    // Zero-beat transaction
    in_valid = 1'b1; in_product = {64'hAB, 64'hCD}; in_rd_lo = 5'd0; in_rd_hi = 5'd0;
    tick();
    in_valid = 1'b0; #1;
    check("zero_valid", wb_valid, 0);
    check("zero_in_ready", in_ready, 1);
    check("zero_retired", retired, 4);
    check("zero_hilo", {hi_q, lo_q}, {64'hAB, 64'hCD});

    // Four back-to-back single-beat products, one beat per cycle
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_product = {64'h0, 64'(100 + i)};
      in_rd_lo = 5'(10 + i); in_rd_hi = 5'd0;
      tick();
      check("b2b_beat", {wb_valid, wb_rd, wb_data, wb_last}, {1'b1, 5'(10 + i), 64'(100 + i), 1'b1});
    end
    in_valid = 1'b0;
    tick();
    check("b2b_done", wb_valid, 0);
    check("b2b_retired", retired, 8);

    // Overflow sticky: set, set-with-clear, lone clear
    in_rd_lo = 5'd0; in_rd_hi = 5'd0;
    in_valid = 1'b1; in_overflow = 1'b1;
    tick();
    in_valid = 1'b0; in_overflow = 1'b0; #1;
    check("ovf_set", ovf_sticky, 1);
    in_valid = 1'b1; in_overflow = 1'b1; ovf_clear = 1'b1;
    tick();
    in_valid = 1'b0; in_overflow = 1'b0; #1;
    check("ovf_set_wins", ovf_sticky, 1);
    tick();
    ovf_clear = 1'b0; #1;
    check("ovf_cleared", ovf_sticky, 0);
    check("ovf_retired", retired, 10);

    // Asynchronous reset during SEND_LO
    wb_ready = 1'b0;
    in_valid = 1'b1; in_product = {64'h5, 64'h6}; in_rd_lo = 5'd1; in_rd_hi = 5'd2;
    tick();
    in_valid = 1'b0; #1;
    check("mid_pre_valid", wb_valid, 1);
    rst = 1'b1; #1;
    check("mid_rst_valid", wb_valid, 0);
    check("mid_rst_hilo", {hi_q, lo_q}, 0);
    check("mid_rst_retired", retired, 0);
    tick();
    rst = 1'b0; wb_ready = 1'b1;
    in_valid = 1'b1; in_product = {64'h99, 64'h88}; in_rd_lo = 5'd9; in_rd_hi = 5'd10;
    tick();
    in_valid = 1'b0; #1;
    check("post_rst_lo", {wb_valid, wb_rd, wb_data, wb_last}, {1'b1, 5'd9, 64'h88, 1'b0});
    tick();
    check("post_rst_hi", {wb_valid, wb_rd, wb_data, wb_last}, {1'b1, 5'd10, 64'h99, 1'b1});
    tick();

    // Counter wrap: 1 accept above plus 16 more gives 17 since reset
    in_rd_lo = 5'd0; in_rd_hi = 5'd0; in_valid = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    in_valid = 1'b0; #1;
    check("wrap_retired", retired, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
